// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared types and constants for the ALU issue controller
// Contents: alu_op_e opcodes, alu_cmd_t queued command, issue_state_e FSM states,
// operand/result/tag widths.
package alu_pkg;

  localparam int ALU_OPND_W = 4;
  localparam int ALU_RES_W  = 6;
  localparam int ALU_SEL_W  = 3;
  // Tag width stored in the command queue; the top-level TAG_W must match it.
  localparam int ALU_TAG_W  = 2;

  typedef enum logic [ALU_SEL_W-1:0] {
    ADD  = 3'd0,
    OR   = 3'd1,
    AND  = 3'd2,
    XOR  = 3'd3,
    XNOR = 3'd4,
    NAND = 3'd5,
    NOR  = 3'd6,
    SUB  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_OPND_W-1:0] a;
    logic [ALU_OPND_W-1:0] b;
    alu_op_e               sel;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CAPT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, ALU-side and result signals of the issue controller
// slave (controller view):  in_* command in, in_ready out; alu_a/b/sel out, alu_result in;
//                           out_valid/result/tag/sel out, out_ready in; count out.
// master (environment view): the same signals with opposite directions.
interface alu_issue_ctrl_if #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [3:0]                 in_a;
  logic [3:0]                 in_b;
  logic [2:0]                 in_sel;
  logic [TAG_W-1:0]           in_tag;
  logic [3:0]                 alu_a;
  logic [3:0]                 alu_b;
  logic [2:0]                 alu_sel;
  logic [5:0]                 alu_result;
  logic                       out_valid;
  logic                       out_ready;
  logic [5:0]                 out_result;
  logic [TAG_W-1:0]           out_tag;
  logic [2:0]                 out_sel;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_tag, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_tag, out_sel, count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, in_tag, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_tag, out_sel, count
  );
endinterface

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// rtl/alu_issue_ctrl_cmd_fifo.sv - synchronous command FIFO for the ALU issue controller
// Ports: clk, rst (sync active-high); push/push_cmd write; pop advances head;
// head is the oldest entry; full/empty/count from registered occupancy.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  alu_cmd_t                   push_cmd,
  input  logic                       pop,
  output alu_cmd_t                   head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  alu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_cmd;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU commands, issues one at a time, returns tagged results
// Ports: clk, rst (sync active-high); bus (alu_issue_ctrl_if.slave) carrying the
// command stream, the registered-ALU operand/result path and the result stream.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH+1);

  issue_state_e         state;
  issue_state_e         state_nxt;
  alu_cmd_t             push_cmd;
  alu_cmd_t             head;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        fifo_count;
  logic [TAG_W-1:0]     pend_tag;
  alu_op_e              pend_sel;

  assign push_cmd = '{a: bus.in_a, b: bus.in_b, sel: alu_op_e'(bus.in_sel), tag: bus.in_tag};

  // Readiness comes from registered occupancy only: a full queue refuses a
  // push even in a cycle where the FSM pops.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign bus.count    = fifo_count;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // HOLD chains straight into DRIVE on a handshake so back-to-back commands
  // cost three cycles each instead of four.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: state_nxt = CAPT;
      CAPT:  state_nxt = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands change only on a pop; the ALU output is sampled only in CAPT,
  // two edges after the operands were loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_sel    <= '0;
      pend_tag       <= '0;
      pend_sel       <= ADD;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
      bus.out_sel    <= '0;
    end else begin
      if (pop) begin
        bus.alu_a   <= head.a;
        bus.alu_b   <= head.b;
        bus.alu_sel <= head.sel;
        pend_tag    <= head.tag;
        pend_sel    <= head.sel;
      end
      if (state == CAPT) begin
        bus.out_result <= bus.alu_result;
        bus.out_tag    <= pend_tag;
        bus.out_sel    <= pend_sel;
        bus.out_valid  <= 1'b1;
      end else if (state == HOLD && bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a registered ALU model
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

  alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'd0:    return {2'b00, a} + {2'b00, b};
      3'd1:    return {2'b00, a | b};
      3'd2:    return {2'b00, a & b};
      3'd3:    return {2'b00, a ^ b};
      3'd4:    return {2'b00, ~(a ^ b)};
      3'd5:    return {2'b00, ~(a & b)};
      3'd6:    return {2'b00, ~(a | b)};
      default: return {2'b00, a} - {2'b00, b};
    endcase
  endfunction

  // Registered ALU sharing clk/rst with the controller.
  logic [5:0] alu_q;
  always @(posedge clk) begin
    if (rst) alu_q <= '0;
    else     alu_q <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);
  end
  assign bus.alu_result = alu_q;

  typedef struct {
    logic [5:0]       res;
    logic [TAG_W-1:0] tag;
    logic [2:0]       sel;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on each handshake and checks that a
  // stalled result does not change.
  exp_t             mon_e;
  logic             hold_v = 1'b0;
  logic [5:0]       hold_res;
  logic [TAG_W-1:0] hold_tag;
  logic [2:0]       hold_sel;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid) begin
        chk("stall_result", bus.out_result, hold_res);
        chk("stall_tag", bus.out_tag, hold_tag);
        chk("stall_sel", bus.out_sel, hold_sel);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", bus.out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("result", bus.out_result, mon_e.res);
          chk("tag", bus.out_tag, mon_e.tag);
          chk("sel_echo", bus.out_sel, mon_e.sel);
          hs_cyc.push_back(cyc);
        end
      end
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_res = bus.out_result;
      hold_tag = bus.out_tag;
      hold_sel = bus.out_sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until accepted; cycles reports how many edges that took.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                      input logic [TAG_W-1:0] tag, input logic [5:0] exp_res,
                      output int cycles);
    logic acc;
    acc          = 1'b0;
    cycles       = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    bus.in_tag   = tag;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    if (acc) sb.push_back('{res: exp_res, tag: tag, sel: sel});
    else     chk("push_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    repeat (3) tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_count"}, bus.count, 0);
    chk({pfx, "_in_ready"}, bus.in_ready, 1);
    chk({pfx, "_out_valid"}, bus.out_valid, 0);
    chk({pfx, "_out_result"}, bus.out_result, 0);
    chk({pfx, "_out_tag"}, bus.out_tag, 0);
    chk({pfx, "_out_sel"}, bus.out_sel, 0);
    chk({pfx, "_alu_a"}, bus.alu_a, 0);
    chk({pfx, "_alu_b"}, bus.alu_b, 0);
    chk({pfx, "_alu_sel"}, bus.alu_sel, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int k;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and idle behaviour.
    chk_reset_vals("reset");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out_valid", bus.out_valid, 0);
    end

    // Single command: 3-cycle latency.
    bus.out_ready = 1'b1;
    push(4'd9, 4'd7, ADD, 2'd1, 6'h10, cycles);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      tick();
      k++;
    end
    chk("latency", k, 3);
    chk("t1_result", bus.out_result, 6'h10);
    chk("t1_tag", bus.out_tag, 1);
    wait_drain();

    // Back-to-back commands: in order, 3 cycles apart.
    n = hs_cyc.size();
    push(4'hA, 4'h6, XOR, 2'd2, 6'h0C, cycles);
    push(4'h5, 4'h3, SUB, 2'd3, 6'h02, cycles);
    wait_drain();
    chk("b2b_results", hs_cyc.size() - n, 2);
    if (hs_cyc.size() >= n + 2) chk("b2b_spacing", hs_cyc[n+1] - hs_cyc[n], 3);

    // Stalled consumer: queue fills to DEPTH with one command in flight.
    bus.out_ready = 1'b0;
    n = hs_cyc.size();
    for (int i = 0; i < 5; i++) begin
      push(4'(i*3+1), 4'(i+2), 3'(i+3), 2'(i+1),
           alu_ref(4'(i*3+1), 4'(i+2), 3'(i+3)), cycles);
      chk("fill_push_cycles", cycles, 1);
    end
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_first_tag", bus.out_tag, 1);
    chk("stall_first_result", bus.out_result, alu_ref(4'd1, 4'd2, 3'd3));
    repeat (4) tick();
    chk("stall_count", bus.count, 4);

    // Push offered in the pop cycle of a full queue: refused, then accepted.
    bus.out_ready = 1'b1;
    push(4'hF, 4'h1, ADD, 2'd0, 6'h10, cycles);
    chk("full_pop_push_cycles", cycles, 2);
    chk("refill_count", bus.count, 4);
    wait_drain();
    chk("fill_drain_results", hs_cyc.size() - n, 6);

    // Reset while DRIVE is active with three commands queued.
    bus.out_ready = 1'b0;
    push(4'h2, 4'h2, AND, 2'd1, 6'h02, cycles);
    push(4'h3, 4'h4, OR,  2'd2, 6'h07, cycles);
    push(4'h6, 4'h1, SUB, 2'd3, 6'h05, cycles);
    push(4'h8, 4'h8, ADD, 2'd0, 6'h10, cycles);
    push(4'h1, 4'h1, NOR, 2'd1, 6'h0E, cycles);
    chk("pre_rst_count", bus.count, 4);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drive_count", bus.count, 3);
    chk("drive_out_valid", bus.out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk_reset_vals("midrst");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_count", bus.count, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Upstream/downstream wrapper for the registered 4-bit ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues them one at a time to the ALU's `a`/`b`/`sel` inputs, then captures the ALU's 6-bit `result` one cycle later.
- Presents that result with the originating tag on a valid/ready output, so producers and consumers never have to model ALU latency themselves.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TAG_W`, 2: width of the user tag carried with each command.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: command present.
- `in_ready`, out, 1: FIFO can accept; equals `!full`.
- `in_a`, in, 4: operand A.
- `in_b`, in, 4: operand B.
- `in_sel`, in, 3: ALU opcode.
- `in_tag`, in, TAG_W: user tag.
- `alu_a`, out, 4: registered operand A to the ALU.
- `alu_b`, out, 4: registered operand B to the ALU.
- `alu_sel`, out, 3: registered opcode to the ALU.
- `alu_result`, in, 6: registered ALU output (1-cycle latency from `alu_*`).
- `out_valid`, out, 1: result held.
- `out_ready`, in, 1: consumer accepts.
- `out_result`, out, 6: captured ALU result.
- `out_tag`, out, TAG_W: tag of that command.
- `out_sel`, out, 3: opcode of that command (echo).
- `count`, out, $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- Push when `in_valid && in_ready`; command is {a, b, sel, tag}.
- `in_ready` is derived from registered occupancy only. A full FIFO refuses a push even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load `alu_a/b/sel` and a pending tag/sel register, go to DRIVE. Otherwise stay.
  - DRIVE: operands stable for one cycle; the ALU samples them at the end of this cycle. Go to CAPT unconditionally.
  - CAPT: `alu_result` is valid. Load `out_result`, `out_tag`, `out_sel`; set `out_valid`; go to HOLD.
  - HOLD: hold outputs until `out_ready`. On handshake, clear `out_valid`, then:
    - FIFO non-empty: pop next head and go directly to DRIVE, with `alu_*` loaded in the same edge.
    - FIFO empty: go to IDLE.
- Exactly one command in flight at any time, so result order always matches command order.
- `alu_*` keep their last values outside DRIVE. They are don't-care to the ALU because the result is only captured in CAPT.
- Push and pop in the same cycle with FIFO non-full: occupancy is unchanged and both operations take effect.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.
- Reset (at any time, including mid-operation):
  - FSM goes to IDLE; FIFO is emptied; in-flight command is discarded.
  - `count`=0, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_tag`=0, `out_sel`=0, `alu_a`=`alu_b`=0, `alu_sel`=0.
  - The ALU shares `rst`, so its result is also 0.

## Timing
- Command accepted at edge E into an empty FIFO with FSM in IDLE:
  - E+1: IDLE pops, `alu_*` valid.
  - E+2: ALU registers the result.
  - E+3: `out_valid`=1.
  - Latency is 3 cycles.
- Back-to-back with `out_ready` held high: one result every 3 cycles (HOLD→DRIVE→CAPT→HOLD).
- `out_valid`/`out_result`/`out_tag` are stable while `out_valid && !out_ready`.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Package `alu_pkg`:
  - `alu_op_e`: 3-bit enum ADD=0, OR=1, AND=2, XOR=3, XNOR=4, NAND=5, NOR=6, SUB=7.
  - `alu_cmd_t` struct: a, b, sel, tag (tag width via parameterized usage or a fixed `ALU_TAG_W`).
  - `issue_state_e` {IDLE, DRIVE, CAPT, HOLD}.
  - Constants `ALU_OPND_W`=4, `ALU_RES_W`=6.
- Sub-module `alu_cmd_fifo`: synchronous FIFO of `alu_cmd_t`, parameter DEPTH, with push/pop/full/empty/count. The FSM and capture registers live in the top.

## Test plan
Bench instantiates `alu_issue_ctrl` wired to the ALU on the same `clk`/`rst`.
- Reset then idle → all outputs 0, `in_ready`=1, `count`=0, `out_valid` never rises.
- Push {a=9, b=7, sel=ADD, tag=1}, `out_ready`=1 → `out_valid` exactly 3 cycles after accept; `out_result`=6'h10, `out_tag`=1.
- Push XOR a=0xA b=0x6 tag=2, then SUB a=5 b=3 tag=3, back-to-back → results 6'h0C (tag 2) then 6'h02 (tag 3), in order, 3 cycles apart.
- Hold `out_ready`=0, push 5 commands with DEPTH=4 → `in_ready` drops when `count`=4 (one command in flight); the first result stays stable and unchanged; releasing `out_ready` drains all in order with correct tags.
- Full FIFO with `in_valid`=1 during the pop cycle → push refused that cycle, accepted the next cycle; no loss or duplication.
- Assert `rst` for one cycle while in DRIVE with 3 entries queued → next cycle all outputs at reset values and `count`=0; no stale result appears afterwards.
